// File: rtl/fsm1_rr_arb.sv
// fsm1_rr_arb
// Round-robin arbiter and sequencer that shares one fsm1 read controller
// between N requesters. The winner gets a single-cycle go to the controller.
// Its grant is held until the controller's ds strobe, and the winner then
// gets a one-cycle completion pulse.
//
// Parameters
//   N    number of requesters (2..16)
//   TMO  watchdog limit in WAIT cycles (used only with FSM1_ARB_WDOG_EN)
//
// Ports
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_req    in   [N] level request per requester
//   i_ds     in   done strobe from the read controller
//   o_gnt    out  [N] current owner of the controller, one-hot or zero
//   o_done   out  [N] one-cycle completion pulse to the owner
//   o_go     out  one-cycle start pulse to the controller
//   o_busy   out  high while a transaction is outstanding
//   o_err    out  sticky watchdog flag (constant 0 without the watchdog)
//   o_state  out  [2] debug view of the FSM state (IDLE=0, WAIT=1, LOCK=2)
//
// Request/completion handshake: a requester raises i_req[k] and holds it
// until it sees o_done[k]. The transfer is complete in the cycle o_done[k] is
// high. A request still high in that cycle is treated as a new request. A
// request dropped while granted does not abort the transaction.
//
// Build option: define FSM1_ARB_WDOG_EN to enable the WAIT watchdog and the
// LOCK state.
module fsm1_rr_arb #(
    parameter int N   = 4,
    parameter int TMO = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    input  logic         i_ds,
    output logic [N-1:0] o_gnt,
    output logic [N-1:0] o_done,
    output logic         o_go,
    output logic         o_busy,
    output logic         o_err,
    output logic [1:0]   o_state
);

    localparam int PW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_LOCK = 2'd2;

    logic [1:0]    r_state;
    logic [PW-1:0] r_ptr;
    logic [N-1:0]  r_gnt;
    logic [N-1:0]  r_done;
    logic          r_go;
    logic          r_busy;

    logic [PW-1:0] w_win;
    logic [PW-1:0] w_idx;
    logic [N-1:0]  w_onehot;
    logic          w_any;
    logic          w_trip;

    // Winner search starts at ptr+1 and wraps modulo N. The scan runs from
    // the farthest offset to the nearest one, so the nearest set bit is the
    // last one written and wins.
    always_comb begin
        w_win    = r_ptr;
        w_idx    = '0;
        w_onehot = '0;
        w_any    = |i_req;
        for (int i = N; i >= 1; i--) begin
            w_idx = PW'((int'(r_ptr) + i) % N);
            if (i_req[w_idx]) begin
                w_win = w_idx;
            end
        end
        w_onehot[w_win] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ptr   <= PW'(N - 1);
            r_gnt   <= '0;
            r_done  <= '0;
            r_go    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_go   <= 1'b0;
            r_done <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_onehot;
                        r_go    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_ptr   <= w_win;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A ds arriving in the same cycle as the watchdog limit
                    // wins and completes normally.
                    if (i_ds) begin
                        r_gnt   <= '0;
                        r_done  <= r_gnt;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_trip) begin
                        r_gnt   <= '0;
                        r_done  <= r_gnt;
                        r_busy  <= 1'b0;
                        r_state <= S_LOCK;
                    end
                end
                // LOCK is parked until rst_n; no further go and req is ignored.
                default: r_state <= r_state;
            endcase
        end
    end

`ifdef FSM1_ARB_WDOG_EN
    localparam int CW = $clog2(TMO + 1);

    logic [CW-1:0] r_cnt;
    logic          r_err;

    // The counter holds the number of WAIT cycles already spent without ds.
    // The trip happens on the edge that would bring it to TMO.
    assign w_trip = (r_state == S_WAIT) && !i_ds && (r_cnt == CW'(TMO - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_cnt <= '0;
            end else if ((r_state == S_WAIT) && !i_ds) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_trip) begin
                r_err <= 1'b1;
            end
        end
    end

    assign o_err = r_err;
`else
    // TMO only matters when the watchdog is built in.
    logic w_unused_tmo;
    assign w_unused_tmo = (TMO > 0);
    assign w_trip       = 1'b0;
    assign o_err        = 1'b0;
`endif

    assign o_gnt   = r_gnt;
    assign o_done  = r_done;
    assign o_go    = r_go;
    assign o_busy  = r_busy;
    assign o_state = r_state;

endmodule

// File: tb/tb_fsm1_rr_arb.sv
// Testbench for fsm1_rr_arb (N=4, TMO=8).
// A behavioural fsm1 controller produces ds 3 + 2*ws cycles after each go.
// A transaction-level reference model predicts every output on every cycle.
// Table vectors, hand sequences and random traffic drive the DUT.
// The watchdog sequence is built only with FSM1_ARB_WDOG_EN.
module tb_fsm1_rr_arb;

  localparam int N   = 4;
  localparam int TMO = 8;
`ifdef FSM1_ARB_WDOG_EN
  localparam int WS_MAX = 2;
`else
  localparam int WS_MAX = 3;
`endif

  logic         clk     = 1'b0;
  logic         rst_n   = 1'b0;
  logic [N-1:0] req     = '0;
  logic         ds_ctl  = 1'b0;
  logic         ds_kick = 1'b0;
  logic         ds;
  logic [N-1:0] gnt;
  logic [N-1:0] done;
  logic         go;
  logic         busy;
  logic         err;
  logic [1:0]   unused_state;

  assign ds = ds_ctl | ds_kick;

  fsm1_rr_arb #(.N(N), .TMO(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_req   (req),
    .i_ds    (ds),
    .o_gnt   (gnt),
    .o_done  (done),
    .o_go    (go),
    .o_busy  (busy),
    .o_err   (err),
    .o_state (unused_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_err  = 0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- fsm1 controller stand-in ----------------
  // go seen in cycle g -> ds high in cycle g+3+2*ws (READ, DLY, [READ, DLY]*ws, DONE).
  int ctl_cd   = 0;
  int ws_n     = 0;
  bit ctl_hang = 1'b0;

  initial forever begin
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      ctl_cd = 0;
      ds_ctl = 1'b0;
    end else begin
      ds_ctl = 1'b0;
      if (go) begin
        ctl_cd = 3 + 2 * ws_n;
      end else if (ctl_cd > 0) begin
        ctl_cd--;
        if (ctl_cd == 0 && !ctl_hang) ds_ctl = 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  int           m_owner = -1;
  int           m_last  = N - 1;
  int           m_wcnt  = 0;
  bit           m_lock  = 1'b0;
  logic [N-1:0] m_gnt   = '0;
  logic [N-1:0] m_done  = '0;
  logic         m_go    = 1'b0;
  logic         m_busy  = 1'b0;
  logic         m_err   = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_owner = -1; m_last = N - 1; m_wcnt = 0; m_lock = 1'b0;
      m_gnt = '0; m_done = '0; m_go = 1'b0; m_busy = 1'b0; m_err = 1'b0;
    end else begin
      m_go   = 1'b0;
      m_done = '0;
      if (m_lock) begin
        m_go = 1'b0;
      end else if (m_owner >= 0) begin
        if (ds) begin
          m_done  = N'(1) << m_owner;
          m_gnt   = '0;
          m_busy  = 1'b0;
          m_owner = -1;
        end else begin
          m_wcnt++;
`ifdef FSM1_ARB_WDOG_EN
          if (m_wcnt == TMO) begin
            m_err   = 1'b1;
            m_done  = N'(1) << m_owner;
            m_gnt   = '0;
            m_busy  = 1'b0;
            m_owner = -1;
            m_lock  = 1'b1;
          end
`endif
        end
      end else if (req != '0) begin
        for (int j = 1; j <= N; j++) begin
          int k;
          k = (m_last + j) % N;
          if (m_owner < 0 && ((req >> k) & N'(1)) != '0) m_owner = k;
        end
        m_last = m_owner;
        m_gnt  = N'(1) << m_owner;
        m_go   = 1'b1;
        m_busy = 1'b1;
        m_wcnt = 0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("mon_gnt",  32'(gnt),  32'(m_gnt));
      chk("mon_done", 32'(done), 32'(m_done));
      chk("mon_go",   32'(go),   32'(m_go));
      chk("mon_busy", 32'(busy), 32'(m_busy));
      chk("mon_err",  32'(err),  32'(m_err));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // which: 0 = go, 1 = done, 2 = err. cyc = negedges waited, -1 on timeout.
  task automatic wait_sig(input int which, input int limit, output int cyc);
    cyc = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge clk);
      if ((which == 0 && go) || (which == 1 && done != '0) || (which == 2 && err)) begin
        cyc = i;
        break;
      end
    end
    if (cyc < 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_%0d: event not seen within %0d cycles", which, limit);
    end
  endtask

  typedef struct {
    logic [N-1:0] req;
    int           ws;
    bit           drop;
    logic [N-1:0] gnt;
  } vec_t;

  vec_t tbl [10];

  initial begin : main
    int           c1;
    int           c2;
    int           ngo;
    logic [N-1:0] r;
    logic [N-1:0] mask;
    logic [N-1:0] exp_q [$];

    // Each entry starts from an idle arbiter; ptr carries over between entries.
    tbl[0] = '{4'b0101, 0,      1'b0, 4'b0001};  // after reset ptr=3 -> 0
    tbl[1] = '{4'b0101, 0,      1'b0, 4'b0100};  // 0 now lowest -> 2
    tbl[2] = '{4'b0001, 0,      1'b0, 4'b0001};
    tbl[3] = '{4'b1010, WS_MAX, 1'b1, 4'b0010};  // req dropped during WAIT
    tbl[4] = '{4'b1010, 0,      1'b0, 4'b1000};
    tbl[5] = '{4'b1111, 1,      1'b0, 4'b0001};  // wrap 3 -> 0
    tbl[6] = '{4'b1001, 1,      1'b0, 4'b1000};
    tbl[7] = '{4'b0110, 0,      1'b0, 4'b0010};  // wrap 3 -> 0 -> 1
    tbl[8] = '{4'b0101, 2,      1'b0, 4'b0100};
    tbl[9] = '{4'b0011, 0,      1'b0, 4'b0001};  // wrap 2 -> 3 -> 0

    // ---- reset state ----
    do_reset();
    chk("rst_gnt",  32'(gnt),  32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_go",   32'(go),   32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_err",  32'(err),  32'(0));
    mon_en = 1'b1;
    @(negedge clk);

    // ---- table vectors ----
    for (int i = 0; i < 10; i++) begin
      req  = tbl[i].req;
      ws_n = tbl[i].ws;
      wait_sig(0, 10, c1);
      chk("tbl_go_lat", 32'(c1), 32'(1));
      chk("tbl_gnt", 32'(gnt), 32'(tbl[i].gnt));
      chk("tbl_busy", 32'(busy), 32'(1));
      if (tbl[i].drop) req = '0;
      wait_sig(1, 40, c2);
      chk("tbl_done_lat", 32'(c2), 32'(4 + 2 * tbl[i].ws));
      chk("tbl_done", 32'(done), 32'(tbl[i].gnt));
      chk("tbl_done_gnt", 32'(gnt), 32'(0));
      chk("tbl_done_busy", 32'(busy), 32'(0));
      req = '0;
      @(negedge clk);
    end

    // ---- all four held: grants 0,1,2,3,0 with go every 5 cycles ----
    do_reset();
    for (int k = 0; k < 5; k++) exp_q.push_back(N'(1) << (k % N));
    req  = 4'b1111;
    ws_n = 0;
    for (int k = 0; k < 5; k++) begin
      wait_sig(0, 12, c1);
      chk("rr_gnt", 32'(gnt), 32'(exp_q.pop_front()));
      if (k > 0) chk("rr_gap", 32'(c1), 32'(5));
      else chk("rr_first", 32'(c1), 32'(1));
    end
    req = '0;
    wait_sig(1, 12, c2);
    @(negedge clk);

    // ---- ds while idle is ignored ----
    ds_kick = 1'b1;
    @(negedge clk);
    ds_kick = 1'b0;
    chk("ds_idle_done", 32'(done), 32'(0));
    chk("ds_idle_busy", 32'(busy), 32'(0));
    @(negedge clk);

    // ---- reset asserted during WAIT ----
    req = 4'b0010;                // last owner 0 -> 1 wins
    wait_sig(0, 10, c1);
    chk("rw_gnt", 32'(gnt), 32'(4'b0010));
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_async_gnt",  32'(gnt),  32'(0));
    chk("rw_async_busy", 32'(busy), 32'(0));
    chk("rw_async_go",   32'(go),   32'(0));
    chk("rw_async_done", 32'(done), 32'(0));
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b0110;                // ptr back at 3 -> 1 wins (2 if ptr survived)
    wait_sig(0, 10, c1);
    chk("rw_after_gnt", 32'(gnt), 32'(4'b0010));
    wait_sig(1, 12, c2);
    chk("rw_after_done", 32'(done), 32'(4'b0010));
    req = '0;
    @(negedge clk);

    // ---- random traffic against the model ----
    r = '0;
    for (int t = 0; t < 800; t++) begin
      for (int b = 0; b < N; b++) begin
        mask = N'(1) << b;
        if ((r & mask) != '0 && (done & mask) != '0 && $urandom_range(0, 1) == 0) r = r & ~mask;
        if ((r & mask) == '0 && $urandom_range(0, 3) == 0) r = r | mask;
      end
      req  = r;
      ws_n = $urandom_range(0, WS_MAX);
      @(negedge clk);
    end
    req = '0;
    repeat (30) @(negedge clk);

`ifdef FSM1_ARB_WDOG_EN
    // ---- watchdog: ws stuck, trip 8 cycles after entering WAIT ----
    do_reset();
    ctl_hang = 1'b1;
    req = 4'b0001;
    wait_sig(0, 10, c1);
    req = '0;
    wait_sig(2, 30, c2);
    chk("wd_lat", 32'(c2), 32'(TMO));
    chk("wd_done", 32'(done), 32'(4'b0001));
    chk("wd_gnt", 32'(gnt), 32'(0));
    req = 4'b1111;
    ngo = 0;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (go) ngo++;
    end
    chk("wd_lock_go", 32'(ngo), 32'(0));
    chk("wd_lock_err", 32'(err), 32'(1));
    ctl_hang = 1'b0;
    do_reset();
    chk("wd_rst_err", 32'(err), 32'(0));
    wait_sig(0, 10, c1);
    chk("wd_regrant", 32'(gnt), 32'(4'b0001));
    req = '0;
    wait_sig(1, 12, c2);
    @(negedge clk);
`else
    ngo = 0;
    chk("no_wd_err", 32'(err), 32'(ngo));
`endif

    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish, got running expected done");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/fsm1_rr_arb.md
# fsm1_rr_arb

Round-robin arbiter and sequencer that shares one `fsm1` read controller (go/ws → rd/ds) between N requesters. It accepts level requests, issues a single-cycle `go` to the controller for the winner, and holds the grant until the controller's `ds` strobe. It then returns a per-requester completion pulse. It sits between the requesting agents and the read controller; `ws` goes directly from memory to the controller and is not handled here.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `TMO`, default 64: watchdog limit in cycles spent in WAIT. Used only with `FSM1_ARB_WDOG_EN`.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `req`  in  N  level request per requester; held until the matching `done` bit.
- `gnt`  out  N  registered, one-hot or zero; the current owner of the controller.
- `done`  out  N  registered, one-cycle completion pulse to the owner.
- `go`  out  1  registered, one-cycle start pulse to the controller.
- `ds`  in  1  done strobe from the controller.
- `busy`  out  1  registered; high while a transaction is outstanding.
- `err`  out  1  registered, sticky watchdog flag; tied 0 when the feature is disabled.

## Operation
- States: IDLE, WAIT, and LOCK (LOCK only with the watchdog).
- Reset values: state=IDLE, `gnt`=0, `done`=0, `go`=0, `busy`=0, `err`=0, `ptr`=N-1, watchdog count=0.
- `ptr` holds the index of the last granted requester.
- IDLE with `req`≠0:
  - Winner k is the first set bit searching from `ptr`+1 upward, wrapping modulo N.
  - Next edge: `gnt[k]`=1, `go`=1, `busy`=1, `ptr`=k, state=WAIT.
- IDLE with `req`=0: hold all outputs at 0.
- WAIT:
  - `go` returns to 0 after one cycle.
  - `gnt[k]` is held regardless of `req[k]`. A request dropped mid-transaction does not abort it.
  - On `ds`=1, next edge: `gnt`=0, `done[k]`=1 for one cycle, `busy`=0, state=IDLE.
- `ds` sampled in IDLE or LOCK is ignored.
- Requests arriving during WAIT queue, since they are level signals.
- The completing requester becomes lowest priority for the next arbitration.
- A requester that keeps `req` high after `done` re-enters arbitration as a new request.
- Every output is a flop; no combinational path runs from inputs to outputs.

## Timing
- `req[k]` rises in cycle c with state IDLE → `gnt[k]` and `go` are high in c+1.
- Controller path after `go` in c+1, with `ws`=0: READ in c+2, DLY in c+3, DONE with `ds`=1 in c+4.
- `done[k]` is high and `gnt`=0 in c+5.
- In c+5 the arbiter is in IDLE and evaluates `req`; the next `go` is at c+6.
- Sustained throughput is therefore 5 cycles per transaction at zero wait states.
- Each cycle of `ws`=1 in DLY adds 2 cycles (DLY→READ→DLY).
- `go` is never issued while `busy`=1. The controller is always in IDLE when `go` arrives.
- Reset mid-transaction clears all state immediately. The controller shares `rst_n`, so both restart in IDLE; no `done` is generated for the aborted transaction.

## Configuration
- `FSM1_ARB_WDOG_EN` defined:
  - A counter of width $clog2(TMO+1) clears on entry to WAIT and increments each WAIT cycle without `ds`.
  - If the counter reaches TMO: next edge `err`=1, `gnt`=0, `done[k]`=1, `busy`=0, state=LOCK.
  - LOCK issues no further `go` and ignores `req`. It is left only by `rst_n`; `err` stays set until then.
  - `ds` in the same cycle the counter reaches TMO wins: normal completion, `err` stays 0.
- `FSM1_ARB_WDOG_EN` undefined: no counter and no LOCK state; `err` is constant 0 and WAIT lasts indefinitely.

## Test plan
- Single request: `req`=0001 in cycle c, `ws`=0 → `gnt`=0001 and `go` in c+1, `ds` in c+4, `done`=0001 in c+5, `busy` low in c+5.
- Simultaneous requests: `req`=0101 after reset → grant order 0 then 2, each with one `go` and one `done`.
- All four requests held continuously → grants 0,1,2,3,0 in order, consecutive `go` pulses 5 cycles apart.
- `ws` held 1 for 3 DLY visits:
  - `gnt` stays stable throughout; `done` arrives 6 cycles later than the zero-wait case.
  - `req` dropped during WAIT still yields `done`.
- Reset asserted in WAIT → all outputs 0 asynchronously; after release, `req`=0010 is granted with `ptr` reset (winner 1).
- With `FSM1_ARB_WDOG_EN` and TMO=8, `ws` stuck 1 → `err`=1 and `done[k]` pulse 8 cycles after entering WAIT. Afterwards there is no `go` despite `req`=1111 until `rst_n` pulses.
